// File: rtl/mx_pkg.sv
// Shared types for the MX operand path: precision/format encodings, the
// payload-beats-per-tile rule and the feeder FSM state encoding.
`timescale 1ns/1ps

package mx_pkg;

  localparam int BUF_W  = 256;
  localparam int ROWS   = 8;
  localparam int BEAT_W = 3;

  typedef enum logic [1:0] {
    PREC_INT8  = 2'b00,
    PREC_FP8_6 = 2'b01,
    PREC_RSVD  = 2'b10,
    PREC_FP4   = 2'b11
  } prec_mode_e;

  typedef enum logic [1:0] {
    FP_E2M3 = 2'b00,
    FP_E3M2 = 2'b01,
    FP_E4M3 = 2'b10,
    FP_E5M2 = 2'b11
  } fp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_PRESENT
  } feeder_state_e;

  // 32-bit payload words needed to carry one 8-row tile in the given format.
  function automatic logic [3:0] payload_beats(input prec_mode_e prec, input fp_mode_e fp);
    logic [3:0] pb;
    case (prec)
      PREC_INT8:  pb = 4'd2;
      PREC_FP8_6: pb = (fp == FP_E2M3 || fp == FP_E3M2) ? 4'd6 : 4'd8;
      default:    pb = 4'd8;
    endcase
    return pb;
  endfunction

endpackage

// File: rtl/mx_tile_unpack.sv
// Combinational views of the 256-bit tile buffer in each supported element
// format; element 0 of every view sits at the buffer LSBs.
`timescale 1ns/1ps

module mx_tile_unpack
  import mx_pkg::*;
(
  input  logic [BUF_W-1:0]         tile_buf,
  output logic [0:7][7:0]          int8,
  output logic [0:7][0:3][7:0]     fp8,
  output logic [0:7][0:3][5:0]     fp6,
  output logic [0:7][0:7][3:0]     fp4
);

  // NOTE: every output gets a default before the loops so no path can hold a stale value (no latch).
  always_comb begin
    int8 = '0;
    fp8  = '0;
    fp6  = '0;
    fp4  = '0;
    for (int i = 0; i < ROWS; i++) begin
      int8[i] = tile_buf[8*i +: 8];
      for (int j = 0; j < 4; j++) begin
        fp8[i][j] = tile_buf[8*(4*i+j) +: 8];
        fp6[i][j] = tile_buf[6*(4*i+j) +: 6];
      end
      for (int j = 0; j < 8; j++) begin
        fp4[i][j] = tile_buf[4*(8*i+j) +: 4];
      end
    end
  end

endmodule

// File: rtl/mx_operand_feeder.sv
// Assembles MX operand tiles (shared exponent + 8 rows) from a 32-bit word
// stream and presents them to one PE operand port with valid/ready.
`timescale 1ns/1ps

module mx_operand_feeder
  import mx_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn,
  input  logic                     start_i,
  input  logic [1:0]               cfg_prec_mode_i,
  input  logic [1:0]               cfg_FP_mode_i,
  input  logic [CNT_W-1:0]         cfg_num_tiles_i,
  input  logic [WORD_W-1:0]        s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [0:7][7:0]          op_INT8_o,
  output logic [0:7][0:3][7:0]     op_FP8_o,
  output logic [0:7][0:3][5:0]     op_FP6_o,
  output logic [0:7][0:7][3:0]     op_FP4_o,
  output logic [7:0]               op_shared_exp_o,
  output logic                     op_valid_o,
  input  logic                     op_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  feeder_state_e state_q, state_d;

  prec_mode_e          prec_q;
  fp_mode_e            fp_q;
  logic [CNT_W-1:0]    num_tiles_q;
  logic [CNT_W-1:0]    tile_cnt_q;
  logic [CNT_W-1:0]    tile_cnt_inc;
  logic [BEAT_W-1:0]   beat_cnt_q;
  logic [BUF_W-1:0]    tile_buf_q;
  logic [7:0]          shared_exp_q;
  logic                err_q;
  logic                done_zero_q;

  logic                start_go;
  logic                start_zero;
  logic                start_err;
  logic                hdr_hs;
  logic                load_hs;
  logic                op_hs;
  logic                last_beat;
  logic                last_tile;
  logic                s_ready;
  logic                op_valid;

  assign tile_cnt_inc = tile_cnt_q + CNT_W'(1);
  assign last_beat    = ({1'b0, beat_cnt_q} == (payload_beats(prec_q, fp_q) - 4'd1));
  assign last_tile    = (tile_cnt_inc == num_tiles_q);

  // NOTE: state register uses non-blocking assignment; all sequential state below does the same.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    op_valid   = 1'b0;
    start_go   = 1'b0;
    start_zero = 1'b0;
    start_err  = 1'b0;
    hdr_hs     = 1'b0;
    load_hs    = 1'b0;
    op_hs      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (prec_mode_e'(cfg_prec_mode_i) == PREC_RSVD) begin
            start_err = 1'b1;
          end else if (cfg_num_tiles_i == '0) begin
            start_zero = 1'b1;
          end else begin
            start_go = 1'b1;
            state_d  = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        s_ready = 1'b1;
        hdr_hs  = s_valid_i;
        if (s_valid_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        load_hs = s_valid_i;
        if (s_valid_i && last_beat) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Valid comes from state alone; ready only steers the transition.
        op_valid = 1'b1;
        op_hs    = op_ready_i;
        if (op_ready_i) state_d = last_tile ? ST_IDLE : ST_HDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the tile buffer is reset because its contents are visible on the op_* outputs.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      prec_q       <= PREC_INT8;
      fp_q         <= FP_E2M3;
      num_tiles_q  <= '0;
      tile_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      tile_buf_q   <= '0;
      shared_exp_q <= '0;
      err_q        <= 1'b0;
      done_zero_q  <= 1'b0;
    end else begin
      done_zero_q <= start_zero;
      if (start_err) err_q <= 1'b1;
      if (start_go || start_zero) err_q <= 1'b0;
      if (start_go) begin
        prec_q      <= prec_mode_e'(cfg_prec_mode_i);
        fp_q        <= fp_mode_e'(cfg_FP_mode_i);
        num_tiles_q <= cfg_num_tiles_i;
        tile_cnt_q  <= '0;
        tile_buf_q  <= '0;
      end
      if (hdr_hs) begin
        shared_exp_q <= s_data_i[7:0];
        beat_cnt_q   <= '0;
      end
      if (load_hs) begin
        tile_buf_q[{beat_cnt_q, 5'd0} +: WORD_W] <= s_data_i;
        if (!last_beat) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
      end
      if (op_hs) begin
        tile_cnt_q <= tile_cnt_inc;
        // Clearing on the way back to HDR keeps unused high bits at zero for narrow formats.
        if (!last_tile) tile_buf_q <= '0;
      end
    end
  end

  mx_tile_unpack u_unpack (
    .tile_buf (tile_buf_q),
    .int8     (op_INT8_o),
    .fp8      (op_FP8_o),
    .fp6      (op_FP6_o),
    .fp4      (op_FP4_o)
  );

  assign s_ready_o       = s_ready;
  assign op_valid_o      = op_valid;
  assign op_shared_exp_o = shared_exp_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_zero_q | (op_hs & last_tile);
  assign err_o           = err_q;

endmodule
